// File: rtl/multiplier_comparator_pkg.sv
// Shared constants and width helpers for the exact/Mitchell multiplier comparator.
// Optional build macro MC_PIPE_EN (used by the top) adds a mid-datapath register stage.
package multiplier_comparator_pkg;

  localparam int MC_DEFAULT_N = 8;

  // Selects which Mitchell reconstruction formula applies to an operand pair
  typedef enum logic [1:0] {
    approxZero  = 2'd0,
    approxBelow = 2'd1,
    approxAbove = 2'd2
  } approxCase_e;

  function automatic int productWidth(input int n);
    return 2 * n;
  endfunction

  function automatic int lodIndexWidth(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/mc_lod.sv
// Combinational leading-one detector: returns the index of the highest set bit
// and a flag that is high when the operand is zero (index is then 0).
module mc_lod
  import multiplier_comparator_pkg::*;
#(
  parameter int N = MC_DEFAULT_N
) (
  input  logic [N-1:0]                value,
  output logic [lodIndexWidth(N)-1:0] position,
  output logic                        isZero
);

  localparam int IW = lodIndexWidth(N);

  // Ascending scan so the highest set bit is the last one to win
  always_comb begin
    position = '0;
    isZero   = (value == '0);
    for (int i = 0; i < N; i++) begin
      if (value[i]) begin
        position = IW'(i);
      end
    end
  end

endmodule

// File: rtl/multiplier_comparator_top.sv
// Exact vs. Mitchell logarithmic multiplier with registered results and error.
// Define MC_PIPE_EN to add a register stage after the leading-one/shift logic (latency 2).
module multiplier_comparator_top
  import multiplier_comparator_pkg::*;
#(
  parameter int N = MC_DEFAULT_N
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [N-1:0]               A,
  input  logic [N-1:0]               B,
  output logic                       out_valid,
  output logic [productWidth(N)-1:0] ExactProduct,
  output logic [productWidth(N)-1:0] ApproxProduct,
  output logic [productWidth(N)-1:0] Error
);

  localparam int PW = productWidth(N);
  localparam int IW = lodIndexWidth(N);
  localparam int WW = PW + 1;

  logic [IW-1:0] kA;
  logic [IW-1:0] kB;
  logic          zeroA;
  logic          zeroB;
  logic [IW:0]   kSum;
  logic [WW-1:0] resA;
  logic [WW-1:0] resB;
  logic [WW-1:0] sumS;
  logic [WW-1:0] powK;
  logic [PW-1:0] exactNext;
  logic          anyZero;

  logic [WW-1:0] stSum;
  logic [WW-1:0] stPow;
  logic [PW-1:0] stExact;
  logic          stZero;
  logic          stValid;

  approxCase_e   approxCase;
  logic [PW-1:0] approxNext;
  logic [PW-1:0] errorNext;

  mc_lod #(.N(N)) lodA (
    .value    (A),
    .position (kA),
    .isZero   (zeroA)
  );

  mc_lod #(.N(N)) lodB (
    .value    (B),
    .position (kB),
    .isZero   (zeroB)
  );

  // Residues and cross-shifted sum; kSum is one bit wider so kA+kB cannot wrap
  always_comb begin
    kSum      = {1'b0, kA} + {1'b0, kB};
    resA      = WW'(A) - (WW'(1) << kA);
    resB      = WW'(B) - (WW'(1) << kB);
    sumS      = (resA << kB) + (resB << kA);
    powK      = WW'(1) << kSum;
    exactNext = PW'(A) * PW'(B);
    anyZero   = zeroA | zeroB;
  end

`ifdef MC_PIPE_EN
  logic [WW-1:0] pipeSum;
  logic [WW-1:0] pipePow;
  logic [PW-1:0] pipeExact;
  logic          pipeZero;
  logic          pipeValid;

  // Intermediate stage between the shift logic and the final add/compare
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipeValid <= 1'b0;
      pipeSum   <= '0;
      pipePow   <= '0;
      pipeExact <= '0;
      pipeZero  <= 1'b0;
    end else begin
      pipeValid <= in_valid;
      if (in_valid) begin
        pipeSum   <= sumS;
        pipePow   <= powK;
        pipeExact <= exactNext;
        pipeZero  <= anyZero;
      end
    end
  end

  assign stSum   = pipeSum;
  assign stPow   = pipePow;
  assign stExact = pipeExact;
  assign stZero  = pipeZero;
  assign stValid = pipeValid;
`else
  assign stSum   = sumS;
  assign stPow   = powK;
  assign stExact = exactNext;
  assign stZero  = anyZero;
  assign stValid = in_valid;
`endif

  // Mitchell reconstruction plus an absolute-difference guard on the error
  always_comb begin
    approxCase = approxAbove;
    if (stZero) begin
      approxCase = approxZero;
    end else if (stSum < stPow) begin
      approxCase = approxBelow;
    end

    approxNext = '0;
    case (approxCase)
      approxZero:  approxNext = '0;
      approxBelow: approxNext = PW'(stPow + stSum);
      default:     approxNext = PW'(stSum << 1);
    endcase

    errorNext = (stExact >= approxNext) ? (stExact - approxNext)
                                        : (approxNext - stExact);
  end

  // All three results come from this one register so they always belong to the same pair
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      ExactProduct  <= '0;
      ApproxProduct <= '0;
      Error         <= '0;
    end else begin
      out_valid <= stValid;
      if (stValid) begin
        ExactProduct  <= stExact;
        ApproxProduct <= approxNext;
        Error         <= errorNext;
      end
    end
  end

endmodule

// File: tb/tb_multiplier_comparator_top.sv
// Self-checking bench for multiplier_comparator_top: directed vectors, random stream
// against an arithmetic reference model, hold behaviour and mid-flight reset.
module tb_multiplier_comparator_top;

  localparam int N  = 8;
  localparam int PW = 2 * N;
`ifdef MC_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int RAND_COUNT = 200;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [N-1:0]  A;
  logic [N-1:0]  B;
  logic          out_valid;
  logic [PW-1:0] ExactProduct;
  logic [PW-1:0] ApproxProduct;
  logic [PW-1:0] Error;

  int checks   = 0;
  int failures = 0;

  multiplier_comparator_top #(.N(N)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .A             (A),
    .B             (B),
    .out_valid     (out_valid),
    .ExactProduct  (ExactProduct),
    .ApproxProduct (ApproxProduct),
    .Error         (Error)
  );

  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input logic [63:0] observed,
                            input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Mitchell product computed directly from its definition with plain integers
  function automatic void refModel(input int a, input int b, output longint exact,
                                   output longint approx, output longint err);
    int     k1;
    int     k2;
    longint s;
    longint p;
    exact = longint'(a) * longint'(b);
    if (a == 0 || b == 0) begin
      approx = 0;
    end else begin
      k1 = 0;
      while ((a >> (k1 + 1)) != 0) k1++;
      k2 = 0;
      while ((b >> (k2 + 1)) != 0) k2++;
      s = ((longint'(a) - (longint'(1) << k1)) << k2) +
          ((longint'(b) - (longint'(1) << k2)) << k1);
      p = longint'(1) << (k1 + k2);
      approx = (s < p) ? (p + s) : (2 * s);
    end
    err = (exact >= approx) ? (exact - approx) : (approx - exact);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated pair, then wait out the pipeline latency
  task automatic applyStimulus(input int a, input int b);
    A        = N'(a);
    B        = N'(b);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (LAT - 1) tick();
  endtask

  task automatic checkOutput(input string tag, input longint ex, input longint ap,
                             input longint er);
    checkValue({tag, "_valid"}, 64'(out_valid), 64'd1);
    checkValue({tag, "_exact"}, 64'(ExactProduct), ex);
    checkValue({tag, "_approx"}, 64'(ApproxProduct), ap);
    checkValue({tag, "_error"}, 64'(Error), er);
  endtask

  int     dirA[8]  = '{0, 255, 0, 255, 1, 3, 6, 16};
  int     dirB[8]  = '{0, 0, 255, 255, 1, 3, 10, 8};
  longint dirEx[8] = '{0, 0, 0, 65025, 1, 9, 60, 128};
  longint dirAp[8] = '{0, 0, 0, 65024, 1, 8, 56, 128};
  longint dirEr[8] = '{0, 0, 0, 1, 0, 1, 4, 0};

  int qa[$];
  int qb[$];

  initial begin
    int     a;
    int     b;
    int     sel;
    int     ea;
    int     eb;
    longint mex;
    longint map;
    longint mer;
    logic   expValid;

    rst_n    = 1'b1;
    in_valid = 1'b0;
    A        = '0;
    B        = '0;
    #2 rst_n = 1'b0;
    #10;
    checkValue("reset_valid", 64'(out_valid), 64'd0);
    checkValue("reset_exact", 64'(ExactProduct), 64'd0);
    checkValue("reset_approx", 64'(ApproxProduct), 64'd0);
    checkValue("reset_error", 64'(Error), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(dirA[i], dirB[i]);
      checkOutput($sformatf("dir%0d", i), dirEx[i], dirAp[i], dirEr[i]);
    end

    // Outputs must hold once out_valid drops
    tick();
    checkValue("hold_valid", 64'(out_valid), 64'd0);
    checkValue("hold_exact", 64'(ExactProduct), 64'd128);
    checkValue("hold_approx", 64'(ApproxProduct), 64'd128);
    checkValue("hold_error", 64'(Error), 64'd0);

    for (int i = 0; i < RAND_COUNT + LAT + 1; i++) begin
      if (i < RAND_COUNT) begin
        sel = int'($urandom_range(0, 9));
        a   = (sel == 0) ? 0 : (sel == 1) ? 255 : int'($urandom_range(0, 255));
        sel = int'($urandom_range(0, 9));
        b   = (sel == 0) ? 0 : (sel == 1) ? 255 : int'($urandom_range(0, 255));
        A        = N'(a);
        B        = N'(b);
        in_valid = 1'b1;
        qa.push_back(a);
        qb.push_back(b);
      end else begin
        in_valid = 1'b0;
      end
      tick();
      expValid = (i >= LAT - 1) && (i - (LAT - 1) < RAND_COUNT);
      checkValue("rand_valid", 64'(out_valid), 64'(expValid));
      if (expValid && qa.size() > 0) begin
        ea = qa.pop_front();
        eb = qb.pop_front();
        refModel(ea, eb, mex, map, mer);
        checkValue("rand_exact", 64'(ExactProduct), mex);
        checkValue("rand_approx", 64'(ApproxProduct), map);
        checkValue("rand_error", 64'(Error), mer);
      end
    end

    // Two pairs in flight, then reset: outputs clear at once and nothing emerges later
    A = 8'd200; B = 8'd100; in_valid = 1'b1;
    tick();
    A = 8'd77;  B = 8'd33;
    tick();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    checkValue("rst_mid_valid", 64'(out_valid), 64'd0);
    checkValue("rst_mid_exact", 64'(ExactProduct), 64'd0);
    checkValue("rst_mid_approx", 64'(ApproxProduct), 64'd0);
    checkValue("rst_mid_error", 64'(Error), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < LAT + 2; i++) begin
      tick();
      checkValue("rst_after_valid", 64'(out_valid), 64'd0);
    end

    // Acceptance works again right after release
    applyStimulus(6, 10);
    checkOutput("post_rst", 60, 56, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/multiplier_comparator_top.md
MULTIPLIER_COMPARATOR_TOP -- requirements
Module: multiplier_comparator

Interface
REQ-001 Parameter N, default 8, operand width in bits; legal range 2..16.
REQ-002 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1, asynchronous active-low reset.
REQ-004 Port in_valid, input, 1, qualifies A/B for sampling on this clock edge.
REQ-005 Port A, input, N, unsigned multiplicand.
REQ-006 Port B, input, N, unsigned multiplier.
REQ-007 Port out_valid, output, 1, high for one cycle per accepted operand pair when results are valid.
REQ-008 Port ExactProduct, output, 2N, exact unsigned product A*B.
REQ-009 Port ApproxProduct, output, 2N, Mitchell logarithmic approximate product.
REQ-010 Port Error, output, 2N, ExactProduct minus ApproxProduct.

Function
REQ-011 Sampling: A/B are captured only on rising clk edges with in_valid=1; there is no backpressure, so a new pair is accepted every cycle.
REQ-012 Exact path: ExactProduct = A*B, full 2N-bit result, no truncation.
REQ-013 Approx path, A=0 or B=0: ApproxProduct = 0.
REQ-014 Approx path, otherwise: k1/k2 = leading-one positions of A/B; r1 = A - 2^k1; r2 = B - 2^k2; S = (r1<<k2) + (r2<<k1).
REQ-015 If S < 2^(k1+k2), ApproxProduct = 2^(k1+k2) + S.
REQ-016 If S >= 2^(k1+k2), ApproxProduct = 2*S.
REQ-017 All intermediate arithmetic is carried in at least 2N+1 bits, so no overflow occurs.
REQ-018 The result is exact integer arithmetic, with no fractional truncation beyond the Mitchell approximation itself.
REQ-019 Error = ExactProduct - ApproxProduct; Mitchell never overestimates, so Error is always >= 0.
REQ-020 If a computed difference would be negative, Error is the absolute difference; this guard is required.
REQ-021 Latency: results and out_valid appear 1 cycle after the accepting edge (MC_PIPE_EN undefined).
REQ-022 The outputs of one operand pair are mutually consistent: all three are driven from the same register stage in the same cycle.
REQ-023 Outputs hold their last value while out_valid=0.
REQ-024 Back-to-back in_valid yields back-to-back out_valid with no bubbles.

Reset
REQ-025 While rst_n=0, out_valid, ExactProduct, ApproxProduct, Error and all pipeline registers are 0, asserted asynchronously.
REQ-026 Release of rst_n is taken synchronously; the first acceptance is possible on the first rising edge after release.
REQ-027 Reset mid-operation discards every in-flight pair; no out_valid is produced for them.

Configuration
REQ-028 Macro MC_PIPE_EN defined: an extra register stage is inserted between the leading-one/shift stage and the final add/compare stage, and latency becomes 2 cycles.
REQ-029 MC_PIPE_EN undefined: latency is 1 cycle.
REQ-030 Results and throughput are otherwise identical with and without MC_PIPE_EN.

Structure
REQ-031 Shared package multiplier_comparator_pkg holds the default width constant (8).
REQ-032 The package also holds the product-width function (2N) and the leading-one index width function (clog2 N).
REQ-033 One sub-module, mc_lod, is a combinational leading-one detector returning the position index plus a zero flag.
REQ-034 mc_lod is instantiated once per operand.

Verification
REQ-035 A=0,B=0 -> Exact=0, Approx=0, Error=0; A=255,B=0 and A=0,B=255 -> all 0.
REQ-036 A=255,B=255 -> Exact=65025, Approx=65024, Error=1; A=1,B=1 -> 1,1,0.
REQ-037 A=3,B=3 -> Exact=9, Approx=8, Error=1; A=6,B=10 -> Exact=60, Approx=56, Error=4; powers of two (A=16,B=8) -> Error=0.
REQ-038 Random pairs with in_valid held high each cycle -> every result matches a reference model at the configured latency, with out_valid continuous.
REQ-039 rst_n asserted while two pairs are in flight -> outputs 0 immediately, and no out_valid appears for those pairs after release.
REQ-040 Build with and without MC_PIPE_EN -> identical result streams, offset by exactly one cycle.
